// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer controllers.
// Gray/binary helpers work on a fixed maximum pointer width; callers zero-extend
// their pointer into ptr_max_t and cast the result back to their own width.
package fifo_pkg;

   localparam int FIFO_DEFAULT_ADDR_WIDTH = 4;
   localparam int FIFO_PTR_MAX_W          = 16;

   typedef logic [FIFO_PTR_MAX_W-1:0] ptr_max_t;

   // Binary to reflected Gray code; bits above the caller's width stay zero.
   function automatic ptr_max_t bin2gray(input ptr_max_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Gray to binary over the low 'width' bits; anything above is ignored.
   function automatic ptr_max_t gray2bin(input ptr_max_t gray, input int width);
      ptr_max_t mask;
      ptr_max_t g;
      ptr_max_t bin;
      mask = (ptr_max_t'(1) << width) - ptr_max_t'(1);
      g    = gray & mask;
      bin  = '0;
      bin[FIFO_PTR_MAX_W-1] = g[FIFO_PTR_MAX_W-1];
      for (int i = FIFO_PTR_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ g[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Generic multi-stage flop chain used to bring a Gray pointer across clock
// domains. Shared by the write-side and read-side pointer controllers.
module fifo_ptr_sync #(
   parameter int width  = 5,
   parameter int stages = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] async_ptr,
   output logic [width-1:0] sync_ptr
);

   logic [width-1:0] chain [stages];

   // Shift the foreign pointer through the chain; reset clears every stage at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < stages; i++) begin
            chain[i] <= '0;
         end
      end else begin
         chain[0] <= async_ptr;
         for (int i = 1; i < stages; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign sync_ptr = chain[stages-1];

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer controller of the asynchronous FIFO.
// Accepts pushes, drives the memory write strobe, keeps binary and Gray write
// pointers, and resynchronises the read pointer for status_gen.
// Optional feature macro: FIFO_WR_LEVEL_EN adds a registered wr_level output.
module fifo_wr_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int addr_width  = FIFO_DEFAULT_ADDR_WIDTH,
   parameter int sync_stages = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [addr_width:0] rd_gray_ptr_in,
   output logic                mem_wr_en,
   output logic [addr_width:0] wt_addr_st_gen,
   output logic [addr_width:0] rd_addr_st_gen,
   output logic [addr_width:0] wt_gray_ptr,
   output logic                push_on_full_error
`ifdef FIFO_WR_LEVEL_EN
   ,
   output logic [addr_width:0] wr_level
`endif
);

   localparam int PTR_W = addr_width + 1;

   // Reject configurations the synchroniser or the Gray helpers cannot support.
   if (sync_stages < 2 || sync_stages > 4 || PTR_W > FIFO_PTR_MAX_W) begin : g_bad_config
      $error("fifo_wr_ptr_ctrl: unsupported sync_stages or addr_width");
   end

   logic                full_int;
   logic [addr_width:0] wt_addr_next;
   logic [addr_width:0] wt_gray_next;
   logic [addr_width:0] rd_gray_sync;

   fifo_ptr_sync #(
      .width  (PTR_W),
      .stages (sync_stages)
   ) u_rd_sync (
      .clk       (clk),
      .rst       (rst),
      .async_ptr (rd_gray_ptr_in),
      .sync_ptr  (rd_gray_sync)
   );

   assign rd_addr_st_gen = PTR_W'(gray2bin(ptr_max_t'(rd_gray_sync), PTR_W));

   // Full when the wrap bits differ and the slot bits match; push is gated off during reset.
   always_comb begin
      full_int  = (wt_addr_st_gen[addr_width] != rd_addr_st_gen[addr_width]) &&
                  (wt_addr_st_gen[addr_width-1:0] == rd_addr_st_gen[addr_width-1:0]);
      mem_wr_en = push & ~full_int & ~rst;
   end

   // Next binary pointer and its Gray image, so both registers load the same value.
   always_comb begin
      wt_addr_next = wt_addr_st_gen + {{addr_width{1'b0}}, mem_wr_en};
      wt_gray_next = PTR_W'(bin2gray(ptr_max_t'(wt_addr_next)));
   end

   // Pointer registers advance together on an accepted push, so the Gray copy never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wt_addr_st_gen <= '0;
         wt_gray_ptr    <= '0;
      end else if (mem_wr_en) begin
         wt_addr_st_gen <= wt_addr_next;
         wt_gray_ptr    <= wt_gray_next;
      end
   end

   // One-cycle error pulse for every push that arrived while full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push_on_full_error <= 1'b0;
      end else begin
         push_on_full_error <= push & full_int;
      end
   end

`ifdef FIFO_WR_LEVEL_EN
   // Occupancy seen from the write side, using the pointer after this cycle's push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_level <= '0;
      end else begin
         wr_level <= wt_addr_next - rd_addr_st_gen;
      end
   end
`else
   // Without the level feature there is no occupancy register at all.
`endif

endmodule
